pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Pipeline control block for the five-stage integer core. Produces the per-stage stall vector and the flush strobe.
- Takes stall requests from the decode stage (operand/load-use hazards) and sequences multi-cycle execute operations (mult/div) with an internal down-counter, so EX and upstream stages freeze for exactly the required cycles.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- CYC_W, 6, width of the multi-cycle length field and the internal busy counter.
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_stallreq_i  in  1  decode-stage hazard request; combinational, level-sensitive.
- ex_start_i  in  1  one-cycle pulse: a multi-cycle op enters EX this cycle.
- ex_cycles_i  in  CYC_W  total EX latency N of that op; sampled only with ex_start_i.
- flush_req_i  in  1  exception/redirect flush request; level, highest priority.
- stall_o  out  6  per-stage stall: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush_o  out  1  flush all pipeline registers this cycle.
- mc_done_o  out  1  one-cycle pulse: multi-cycle op result valid in EX this cycle.
- mc_abort_o  out  1  one-cycle pulse: in-flight multi-cycle op killed by flush.
- busy_o  out  1  high while state is MC_BUSY.
- stall_cnt_o  out  PERF_W  count of cycles with stall_o != 0.

Behaviour:
- States: IDLE, MC_BUSY. Registered: state, cnt[CYC_W-1:0], stall_cnt_o.
- stall_o, flush_o, mc_done_o and mc_abort_o are combinational (Mealy) from state, cnt and inputs.
- While rst=1, all outputs are 0. On the clock edge with rst=1: state<=IDLE, cnt<=0, stall_cnt_o<=0. Reset mid-operation abandons the op with no mc_done_o or mc_abort_o pulse.
- Priority per cycle: flush_req_i > MC_BUSY sequencing > ex_start_i > id_stallreq_i.
- Flush:
  - When flush_req_i=1 in any state: flush_o=1, stall_o=6'b000000, mc_done_o=0.
  - mc_abort_o=1 only if state==MC_BUSY.
  - Next state IDLE, cnt<=0. ex_start_i in the same cycle is ignored.
- IDLE, no flush:
  - If ex_start_i=1 and N>=2: stall_o=6'b001111 this cycle, cnt<=N-2, next state MC_BUSY.
  - If ex_start_i=1 and N is 0 or 1: treated as single-cycle; no stall, stay IDLE.
  - Otherwise, if id_stallreq_i=1: stall_o=6'b000111; else stall_o=0.
- MC_BUSY, no flush:
  - If cnt!=0: stall_o=6'b001111, cnt<=cnt-1.
  - If cnt==0: stall_o=0, mc_done_o=1, next state IDLE.
  - ex_start_i is ignored (EX is frozen). id_stallreq_i is subsumed by the EX stall.
- Latency: an N-cycle op (N>=2) produces exactly N-1 consecutive stall cycles, starting with the ex_start_i cycle. mc_done_o occurs N-1 cycles after ex_start_i.
- Maximum N = 2^CYC_W-1 (63), giving 62 stall cycles. No wrap: cnt never decrements below 0.
- stall_cnt_o increments by 1 at each edge where stall_o != 0 and rst=0. It saturates at all-ones and does not wrap.
- busy_o = (state==MC_BUSY). It is independent of flush_req_i in the current cycle.
- Back-to-back ops: ex_start_i in the same cycle as mc_done_o is ignored. A new op may start from the next IDLE cycle.

Test Plan:
- Reset: hold rst 3 cycles with all inputs toggling -> all outputs 0, stall_cnt_o=0, busy_o=0. Release, inputs 0 -> stall_o=0.
- Decode hazard: id_stallreq_i=1 for 2 cycles in IDLE -> stall_o=6'b000111 both cycles, then 0; stall_cnt_o=2.
- Multi-cycle op: ex_start_i pulse with ex_cycles_i=4 -> stall_o=6'b001111 for cycles T..T+2, mc_done_o=1 and stall_o=0 at T+3, busy_o high T+1..T+3, stall_cnt_o=3.
- Degenerate lengths: ex_cycles_i=1, then 0, then 2 -> no stall, no stall, one stall cycle then mc_done_o next cycle. ex_cycles_i=63 -> 62 stall cycles.
- Flush mid-op: ex_cycles_i=10, flush_req_i at T+3 with id_stallreq_i=1 -> flush_o=1, mc_abort_o=1, stall_o=0 at T+3; IDLE at T+4; no mc_done_o; stall_cnt_o=3.
- Saturation and reset mid-op: preload via a long stall until stall_cnt_o=all-ones -> holds all-ones. Assert rst during MC_BUSY -> next cycle IDLE, counter 0, no done or abort pulse.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: decode hazard stalls, multi-cycle EX sequencing
// with a down-counter, and a saturating stall-cycle performance counter.
module pipe_stall_ctrl #(
  parameter int CYC_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stallreq_i,
  input  logic              ex_start_i,
  input  logic [CYC_W-1:0]  ex_cycles_i,
  input  logic              flush_req_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              mc_done_o,
  output logic              mc_abort_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;

  state_t              state_r, state_nx;
  logic [CYC_W-1:0]    cnt_r, cnt_nx;
  logic [PERF_W-1:0]   perf_r;
  logic [5:0]          stall_s;
  logic                flush_s, done_s, abort_s;

  // State, busy counter and saturating perf counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CYC_W{1'b0}};
      perf_r  <= {PERF_W{1'b0}};
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      if ((stall_s != 6'b000000) && (perf_r != {PERF_W{1'b1}})) begin
        perf_r <= perf_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        perf_r <= perf_r;
      end
    end
  end

  // Next-state and Mealy outputs; flush outranks everything, reset forces all quiet
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    stall_s  = 6'b000000;
    flush_s  = 1'b0;
    done_s   = 1'b0;
    abort_s  = 1'b0;
    if (rst) begin
      state_nx = IDLE;
      cnt_nx   = {CYC_W{1'b0}};
    end else if (flush_req_i) begin
      flush_s  = 1'b1;
      abort_s  = (state_r == MC_BUSY);
      state_nx = IDLE;
      cnt_nx   = {CYC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // Lengths 0 and 1 complete in the start cycle, so they never stall
          if (ex_start_i && (ex_cycles_i >= CYC_W'(2))) begin
            stall_s  = STALL_EX;
            cnt_nx   = ex_cycles_i - CYC_W'(2);
            state_nx = MC_BUSY;
          end else if (id_stallreq_i) begin
            stall_s = STALL_ID;
          end else begin
            stall_s = 6'b000000;
          end
        end
        MC_BUSY: begin
          if (cnt_r != {CYC_W{1'b0}}) begin
            stall_s = STALL_EX;
            cnt_nx  = cnt_r - CYC_W'(1);
          end else begin
            done_s   = 1'b1;
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = {CYC_W{1'b0}};
        end
      endcase
    end
  end

  assign stall_o     = stall_s;
  assign flush_o     = flush_s;
  assign mc_done_o   = done_s;
  assign mc_abort_o  = abort_s;
  assign busy_o      = !rst && (state_r == MC_BUSY);
  assign stall_cnt_o = rst ? {PERF_W{1'b0}} : perf_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, hand sequences
// for long ops / saturation / reset mid-op, and random stimulus against a model.
module tb_pipe_stall_ctrl;

  localparam int CYC_W  = 6;
  localparam int PERF_W = 8;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_stallreq_i = 1'b0;
  logic              ex_start_i = 1'b0;
  logic [CYC_W-1:0]  ex_cycles_i = '0;
  logic              flush_req_i = 1'b0;
  logic [5:0]        stall_o;
  logic              flush_o, mc_done_o, mc_abort_o, busy_o;
  logic [PERF_W-1:0] stall_cnt_o;

  pipe_stall_ctrl #(.CYC_W(CYC_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .id_stallreq_i(id_stallreq_i), .ex_start_i(ex_start_i),
    .ex_cycles_i(ex_cycles_i), .flush_req_i(flush_req_i), .stall_o(stall_o),
    .flush_o(flush_o), .mc_done_o(mc_done_o), .mc_abort_o(mc_abort_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles remaining until the done pulse (0 = idle) and stall total
  int m_left = 0, m_cnt = 0, nx_left = 0, nx_cnt = 0;
  logic [5:0] e_stall;
  logic e_flush, e_done, e_abort, e_busy;
  int e_cnt;

  typedef struct {
    logic rst, id, st;
    logic [5:0] n;
    logic fl;
    logic [5:0] stall;
    logic flush, done, abort, busy;
    int cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic i, logic s, int n, logic f,
                              logic [5:0] st, logic fo, logic d, logic a, logic b, int c);
    vec_t v;
    v.rst = r; v.id = i; v.st = s; v.n = 6'(n); v.fl = f;
    v.stall = st; v.flush = fo; v.done = d; v.abort = a; v.busy = b; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic predict();
    e_stall = 6'b0; e_flush = 1'b0; e_done = 1'b0; e_abort = 1'b0;
    e_busy = (m_left > 0) && !rst;
    e_cnt = rst ? 0 : m_cnt;
    nx_left = m_left;
    if (rst) begin
      nx_left = 0;
    end else if (flush_req_i) begin
      e_flush = 1'b1;
      e_abort = (m_left > 0);
      nx_left = 0;
    end else if (m_left == 1) begin
      e_done = 1'b1;
      nx_left = 0;
    end else if (m_left > 1) begin
      e_stall = 6'b001111;
      nx_left = m_left - 1;
    end else if (ex_start_i && ex_cycles_i >= 2) begin
      e_stall = 6'b001111;
      nx_left = int'(ex_cycles_i) - 1;
    end else if (id_stallreq_i) begin
      e_stall = 6'b000111;
    end
    if (rst) nx_cnt = 0;
    else if (e_stall != 0 && m_cnt < PERF_MAX) nx_cnt = m_cnt + 1;
    else nx_cnt = m_cnt;
  endtask

  // Drive one cycle's inputs, then check the DUT against the model at the falling edge
  task automatic step(logic r, logic i, logic s, int n, logic f);
    rst = r; id_stallreq_i = i; ex_start_i = s; ex_cycles_i = 6'(n); flush_req_i = f;
    @(negedge clk);
    predict();
    chk("model_stall", int'(stall_o), int'(e_stall));
    chk("model_flush", int'(flush_o), int'(e_flush));
    chk("model_done", int'(mc_done_o), int'(e_done));
    chk("model_abort", int'(mc_abort_o), int'(e_abort));
    chk("model_busy", int'(busy_o), int'(e_busy));
    chk("model_cnt", int'(stall_cnt_o), e_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    m_left = nx_left;
    m_cnt = nx_cnt;
    #1;
  endtask

  initial begin
    // reset with toggling inputs, decode hazard, N=4 op, degenerate lengths, flush mid-op
    vecs[0]  = mk(1,1,1, 4,0, 6'h00,0,0,0,0,0);
    vecs[1]  = mk(1,0,0, 0,1, 6'h00,0,0,0,0,0);
    vecs[2]  = mk(1,1,1,63,1, 6'h00,0,0,0,0,0);
    vecs[3]  = mk(0,0,0, 0,0, 6'h00,0,0,0,0,0);
    vecs[4]  = mk(0,1,0, 0,0, 6'h07,0,0,0,0,0);
    vecs[5]  = mk(0,1,0, 0,0, 6'h07,0,0,0,0,1);
    vecs[6]  = mk(0,0,0, 0,0, 6'h00,0,0,0,0,2);
    vecs[7]  = mk(0,0,1, 4,0, 6'h0F,0,0,0,0,2);
    vecs[8]  = mk(0,0,0, 0,0, 6'h0F,0,0,0,1,3);
    vecs[9]  = mk(0,0,0, 0,0, 6'h0F,0,0,0,1,4);
    vecs[10] = mk(0,0,0, 0,0, 6'h00,0,1,0,1,5);
    vecs[11] = mk(0,0,0, 0,0, 6'h00,0,0,0,0,5);
    vecs[12] = mk(0,0,1, 1,0, 6'h00,0,0,0,0,5);
    vecs[13] = mk(0,0,1, 0,0, 6'h00,0,0,0,0,5);
    vecs[14] = mk(0,0,1, 2,0, 6'h0F,0,0,0,0,5);
    vecs[15] = mk(0,1,1, 4,0, 6'h00,0,1,0,1,6);
    vecs[16] = mk(0,0,0, 0,0, 6'h00,0,0,0,0,6);
    vecs[17] = mk(0,0,1,10,0, 6'h0F,0,0,0,0,6);
    vecs[18] = mk(0,1,0, 0,0, 6'h0F,0,0,0,1,7);
    vecs[19] = mk(0,0,0, 0,0, 6'h0F,0,0,0,1,8);
    vecs[20] = mk(0,1,1, 5,1, 6'h00,1,0,1,1,9);
    vecs[21] = mk(0,0,0, 0,0, 6'h00,0,0,0,0,9);
    vecs[22] = mk(0,1,0, 0,1, 6'h00,1,0,0,0,9);
    vecs[23] = mk(0,0,0, 0,0, 6'h00,0,0,0,0,9);

    for (int k = 0; k < 24; k++) begin
      step(vecs[k].rst, vecs[k].id, vecs[k].st, int'(vecs[k].n), vecs[k].fl);
      chk($sformatf("vec%0d_stall", k), int'(stall_o), int'(vecs[k].stall));
      chk($sformatf("vec%0d_flush", k), int'(flush_o), int'(vecs[k].flush));
      chk($sformatf("vec%0d_done", k), int'(mc_done_o), int'(vecs[k].done));
      chk($sformatf("vec%0d_abort", k), int'(mc_abort_o), int'(vecs[k].abort));
      chk($sformatf("vec%0d_busy", k), int'(busy_o), int'(vecs[k].busy));
      chk($sformatf("vec%0d_cnt", k), int'(stall_cnt_o), vecs[k].cnt);
      tick();
    end

    // Maximum length: 62 stall cycles, done on the 63rd
    step(0,0,1,63,0);
    chk("n63_first_stall", int'(stall_o), 32'h0F);
    tick();
    for (int k = 1; k < 62; k++) begin
      step(0,0,0,0,0);
      chk("n63_stall", int'(stall_o), 32'h0F);
      chk("n63_nodone", int'(mc_done_o), 0);
      tick();
    end
    step(0,0,0,0,0);
    chk("n63_done", int'(mc_done_o), 1);
    chk("n63_nostall", int'(stall_o), 0);
    chk("n63_cnt", int'(stall_cnt_o), 9 + 62);
    tick();

    // Long decode stall drives the counter into saturation
    for (int k = 0; k < 200; k++) begin
      step(0,1,0,0,0);
      tick();
    end
    step(0,1,0,0,0);
    chk("sat_hold", int'(stall_cnt_o), PERF_MAX);
    tick();
    step(0,0,0,0,0);
    chk("sat_nowrap", int'(stall_cnt_o), PERF_MAX);
    tick();

    // Reset during MC_BUSY: no done/abort, back to idle with counter cleared
    step(0,0,1,20,0); tick();
    step(0,0,0,0,0); tick();
    step(1,0,0,0,0);
    chk("rstmid_done", int'(mc_done_o), 0);
    chk("rstmid_abort", int'(mc_abort_o), 0);
    chk("rstmid_busy", int'(busy_o), 0);
    tick();
    step(0,0,0,0,0);
    chk("rstmid_idle", int'(busy_o), 0);
    chk("rstmid_cnt", int'(stall_cnt_o), 0);
    chk("rstmid_stall", int'(stall_o), 0);
    chk("rstmid_done2", int'(mc_done_o), 0);
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6)),
           ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
